// File: rtl/ddr3_xfer_sched_if.sv
// ---------------------------------------------------------------------------
// ddr3_xfer_sched_if
//   Bundles every signal exchanged by the two-client DDR3 transfer scheduler.
//   The signals fall into three groups:
//     - Client side, one set per client (c0, c1):
//       req/wr/count/buf_addr/ddr3_addr go in; ack/done/fault come out.
//     - Engine side:
//       ibuf/obuf go, count and address go out; busy and fault come in.
//     - Status: PHY init done comes in; o_busy and o_owner go out.
//   Modports:
//     master : the scheduler itself.
//     slave  : whatever surrounds it (control logic, engine, testbench).
// ---------------------------------------------------------------------------
interface ddr3_xfer_sched_if #(
  parameter int BUF_DEPTH      = 10,
  parameter int MEM_ADDR_DEPTH = 28
);
  logic                      i_app_phy_init_done;

  logic                      i_c0_req;
  logic                      i_c0_wr;
  logic [BUF_DEPTH-1:0]      i_c0_count;
  logic [BUF_DEPTH-1:0]      i_c0_buf_addr;
  logic [MEM_ADDR_DEPTH-1:0] i_c0_ddr3_addr;
  logic                      o_c0_ack;
  logic                      o_c0_done;
  logic                      o_c0_fault;

  logic                      i_c1_req;
  logic                      i_c1_wr;
  logic [BUF_DEPTH-1:0]      i_c1_count;
  logic [BUF_DEPTH-1:0]      i_c1_buf_addr;
  logic [MEM_ADDR_DEPTH-1:0] i_c1_ddr3_addr;
  logic                      o_c1_ack;
  logic                      o_c1_done;
  logic                      o_c1_fault;

  logic                      o_ibuf_go;
  logic                      o_obuf_go;
  logic [BUF_DEPTH-1:0]      o_ibuf_count;
  logic [BUF_DEPTH-1:0]      o_obuf_count;
  logic [BUF_DEPTH-1:0]      o_ibuf_start_addrb;
  logic [BUF_DEPTH-1:0]      o_obuf_start_addra;
  logic [MEM_ADDR_DEPTH-1:0] o_ibuf_ddr3_addrb;
  logic [MEM_ADDR_DEPTH-1:0] o_obuf_ddr3_addra;
  logic                      i_ibuf_bsy;
  logic                      i_obuf_bsy;
  logic                      i_ibuf_ddr3_fault;
  logic                      i_obuf_ddr3_fault;

  logic                      o_busy;
  logic                      o_owner;

  modport master (
    input  i_app_phy_init_done,
    input  i_c0_req, i_c0_wr, i_c0_count, i_c0_buf_addr, i_c0_ddr3_addr,
    output o_c0_ack, o_c0_done, o_c0_fault,
    input  i_c1_req, i_c1_wr, i_c1_count, i_c1_buf_addr, i_c1_ddr3_addr,
    output o_c1_ack, o_c1_done, o_c1_fault,
    output o_ibuf_go, o_obuf_go, o_ibuf_count, o_obuf_count,
    output o_ibuf_start_addrb, o_obuf_start_addra,
    output o_ibuf_ddr3_addrb, o_obuf_ddr3_addra,
    input  i_ibuf_bsy, i_obuf_bsy, i_ibuf_ddr3_fault, i_obuf_ddr3_fault,
    output o_busy, o_owner
  );

  modport slave (
    output i_app_phy_init_done,
    output i_c0_req, i_c0_wr, i_c0_count, i_c0_buf_addr, i_c0_ddr3_addr,
    input  o_c0_ack, o_c0_done, o_c0_fault,
    output i_c1_req, i_c1_wr, i_c1_count, i_c1_buf_addr, i_c1_ddr3_addr,
    input  o_c1_ack, o_c1_done, o_c1_fault,
    input  o_ibuf_go, o_obuf_go, o_ibuf_count, o_obuf_count,
    input  o_ibuf_start_addrb, o_obuf_start_addra,
    input  o_ibuf_ddr3_addrb, o_obuf_ddr3_addra,
    output i_ibuf_bsy, i_obuf_bsy, i_ibuf_ddr3_fault, i_obuf_ddr3_fault,
    input  o_busy, o_owner
  );
endinterface

// File: rtl/ddr3_xfer_sched.sv
// ---------------------------------------------------------------------------
// ddr3_xfer_sched
//   Two-client round-robin scheduler in front of the DDR3 transfer engine.
//   Each client requests either a buffer->DDR3 job (wr=1, ibuf lines) or a
//   DDR3->buffer job (wr=0, obuf lines). The scheduler:
//     - grants one job at a time and latches its parameters;
//     - pulses the matching engine go line;
//     - follows the engine busy handshake;
//     - reports done/fault back to the client that owned the job.
//   Ports:
//     ui_clk : clock, all logic on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : ddr3_xfer_sched_if.master (client, engine and status signals)
// ---------------------------------------------------------------------------
module ddr3_xfer_sched #(
  parameter int BUF_DEPTH      = 10,
  parameter int MEM_ADDR_DEPTH = 28,
  parameter int START_TIMEOUT  = 16
) (
  input  logic               ui_clk,
  input  logic               rst_n,
  ddr3_xfer_sched_if.master  bus
);

  localparam int TMO_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    RUN      = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  // Client inputs gathered into indexable form.
  logic [1:0]                req;
  logic [1:0]                wr;
  logic [BUF_DEPTH-1:0]      cnt      [2];
  logic [BUF_DEPTH-1:0]      buf_a    [2];
  logic [MEM_ADDR_DEPTH-1:0] ddr_a    [2];

  assign req      = {bus.i_c1_req, bus.i_c0_req};
  assign wr       = {bus.i_c1_wr,  bus.i_c0_wr};
  assign cnt[0]   = bus.i_c0_count;
  assign cnt[1]   = bus.i_c1_count;
  assign buf_a[0] = bus.i_c0_buf_addr;
  assign buf_a[1] = bus.i_c1_buf_addr;
  assign ddr_a[0] = bus.i_c0_ddr3_addr;
  assign ddr_a[1] = bus.i_c1_ddr3_addr;

  state_t                    state_reg,      state_next;
  logic                      owner_reg,      owner_next;
  logic                      last_owner_reg, last_owner_next;
  logic                      wr_reg,         wr_next;
  logic [BUF_DEPTH-1:0]      count_reg,      count_next;
  logic [BUF_DEPTH-1:0]      buf_addr_reg,   buf_addr_next;
  logic [MEM_ADDR_DEPTH-1:0] ddr3_addr_reg,  ddr3_addr_next;
  logic [TMO_W-1:0]          tmo_reg,        tmo_next;
  logic [1:0]                ack_reg,        ack_next;
  logic [1:0]                done_reg,       done_next;
  logic [1:0]                fault_reg,      fault_next;
  logic                      ibuf_go_reg,    ibuf_go_next;
  logic                      obuf_go_reg,    obuf_go_next;

  logic                      grant_sel;
  logic                      sel_bsy;
  logic                      sel_fault;
  logic [TMO_W-1:0]          tmo_inc;

  // State and output registers.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;   // client 0 wins the first tie
      wr_reg         <= 1'b0;
      count_reg      <= '0;
      buf_addr_reg   <= '0;
      ddr3_addr_reg  <= '0;
      tmo_reg        <= '0;
      ack_reg        <= '0;
      done_reg       <= '0;
      fault_reg      <= '0;
      ibuf_go_reg    <= 1'b0;
      obuf_go_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      wr_reg         <= wr_next;
      count_reg      <= count_next;
      buf_addr_reg   <= buf_addr_next;
      ddr3_addr_reg  <= ddr3_addr_next;
      tmo_reg        <= tmo_next;
      ack_reg        <= ack_next;
      done_reg       <= done_next;
      fault_reg      <= fault_next;
      ibuf_go_reg    <= ibuf_go_next;
      obuf_go_reg    <= obuf_go_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    wr_next         = wr_reg;
    count_next      = count_reg;
    buf_addr_next   = buf_addr_reg;
    ddr3_addr_next  = ddr3_addr_reg;
    tmo_next        = tmo_reg;
    ack_next        = '0;
    done_next       = '0;
    fault_next      = fault_reg;
    ibuf_go_next    = ibuf_go_reg;
    obuf_go_next    = obuf_go_reg;

    tmo_inc   = tmo_reg + TMO_W'(1);
    // Engine handshake of the direction the current job uses.
    sel_bsy   = wr_reg ? bus.i_ibuf_bsy        : bus.i_obuf_bsy;
    sel_fault = wr_reg ? bus.i_ibuf_ddr3_fault : bus.i_obuf_ddr3_fault;
    // Single requester wins outright; on a tie the client that did not own
    // the previous job wins.
    grant_sel = (req == 2'b11) ? ~last_owner_reg : req[1];

    case (state_reg)
      IDLE: begin
        if (bus.i_app_phy_init_done && (req != 2'b00)) begin
          owner_next            = grant_sel;
          ack_next[grant_sel]   = 1'b1;
          fault_next[grant_sel] = 1'b0;
          wr_next               = wr[grant_sel];
          count_next            = cnt[grant_sel];
          buf_addr_next         = buf_a[grant_sel];
          ddr3_addr_next        = ddr_a[grant_sel];
          tmo_next              = '0;
          if (cnt[grant_sel] == '0) begin
            // Nothing to move: skip the engine entirely.
            state_next = COMPLETE;
          end else begin
            state_next   = ISSUE;
            ibuf_go_next = wr[grant_sel];
            obuf_go_next = ~wr[grant_sel];
          end
        end
      end

      ISSUE: begin
        if (sel_bsy) begin
          ibuf_go_next = 1'b0;
          obuf_go_next = 1'b0;
          state_next   = RUN;
        end else begin
          tmo_next = tmo_inc;
          if (tmo_inc == TMO_W'(START_TIMEOUT)) begin
            // Engine never acknowledged the go strobe.
            ibuf_go_next          = 1'b0;
            obuf_go_next          = 1'b0;
            fault_next[owner_reg] = 1'b1;
            done_next[owner_reg]  = 1'b1;
            state_next            = COMPLETE;
          end
        end
      end

      RUN: begin
        if (!sel_bsy) begin
          fault_next[owner_reg] = sel_fault;
          done_next[owner_reg]  = 1'b1;
          state_next            = COMPLETE;
        end
      end

      COMPLETE: begin
        // Jobs arriving from ISSUE/RUN already have done showing this cycle.
        // A zero-count job arrives straight from IDLE, so it spends one more
        // cycle here to give its done pulse a cycle of its own after the ack.
        if (done_reg[owner_reg]) begin
          last_owner_next = owner_reg;
          state_next      = IDLE;
        end else begin
          done_next[owner_reg] = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Outputs. The same latched job parameters feed both engine ports.
  assign bus.o_c0_ack           = ack_reg[0];
  assign bus.o_c1_ack           = ack_reg[1];
  assign bus.o_c0_done          = done_reg[0];
  assign bus.o_c1_done          = done_reg[1];
  assign bus.o_c0_fault         = fault_reg[0];
  assign bus.o_c1_fault         = fault_reg[1];
  assign bus.o_ibuf_go          = ibuf_go_reg;
  assign bus.o_obuf_go          = obuf_go_reg;
  assign bus.o_ibuf_count       = count_reg;
  assign bus.o_obuf_count       = count_reg;
  assign bus.o_ibuf_start_addrb = buf_addr_reg;
  assign bus.o_obuf_start_addra = buf_addr_reg;
  assign bus.o_ibuf_ddr3_addrb  = ddr3_addr_reg;
  assign bus.o_obuf_ddr3_addra  = ddr3_addr_reg;
  assign bus.o_busy             = (state_reg != IDLE);
  assign bus.o_owner            = owner_reg;

endmodule

// File: tb/tb_ddr3_xfer_sched.sv
// ---------------------------------------------------------------------------
// tb_ddr3_xfer_sched
//   Directed stimulus for ddr3_xfer_sched with a scoreboard. The stimulus
//   process pushes the expected job record before raising a request. A
//   separate monitor pops the record on each ack and finishes checking it on
//   the matching done. A small engine model answers the go strobes.
// ---------------------------------------------------------------------------
module tb_ddr3_xfer_sched;

  logic ui_clk = 1'b0;
  logic rst_n  = 1'b0;

  always #5 ui_clk = ~ui_clk;

  ddr3_xfer_sched_if #(.BUF_DEPTH(10), .MEM_ADDR_DEPTH(28)) bus ();

  ddr3_xfer_sched #(
    .BUF_DEPTH(10), .MEM_ADDR_DEPTH(28), .START_TIMEOUT(16)
  ) dut (
    .ui_clk (ui_clk),
    .rst_n  (rst_n),
    .bus    (bus.master)
  );

  typedef struct {
    int   client;
    logic wr;
    int   cnt;
    int   ba;
    int   da;
    logic fault;
    int   go_cycles;
    int   done_dly;
    int   ack_cyc;     // -1 = arrival cycle not checked
  } item_t;

  item_t exp_q[$];
  int    n_checks   = 0;
  int    n_fail     = 0;
  int    cyc        = 0;
  int    ack_count  = 0;
  int    done_count = 0;
  bit    mon_active = 0;
  logic  exp_fault [2];

  // Engine model controls.
  int    eng_dur     = 10;
  bit    eng_respond = 1;
  bit    eng_fault   = 0;

  wire any_out = bus.o_c0_ack | bus.o_c1_ack | bus.o_c0_done | bus.o_c1_done |
                 bus.o_c0_fault | bus.o_c1_fault | bus.o_ibuf_go | bus.o_obuf_go |
                 (|bus.o_ibuf_count) | (|bus.o_obuf_count) |
                 (|bus.o_ibuf_start_addrb) | (|bus.o_obuf_start_addra) |
                 (|bus.o_ibuf_ddr3_addrb) | (|bus.o_obuf_ddr3_addra) |
                 bus.o_busy | bus.o_owner;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  initial forever begin
    @(posedge ui_clk);
    cyc++;
  end

  // Engine model: go seen in a cycle -> busy high from the next edge for
  // eng_dur cycles; the fault level is presented as busy falls.
  initial begin
    bit is_ib;
    bus.i_ibuf_bsy = 0; bus.i_obuf_bsy = 0;
    bus.i_ibuf_ddr3_fault = 0; bus.i_obuf_ddr3_fault = 0;
    forever begin
      @(posedge ui_clk); #1;
      if (rst_n && eng_respond && (bus.o_ibuf_go || bus.o_obuf_go)) begin
        is_ib = bus.o_ibuf_go;
        @(posedge ui_clk); #1;
        if (is_ib) bus.i_ibuf_bsy = 1; else bus.i_obuf_bsy = 1;
        repeat (eng_dur) @(posedge ui_clk);
        #1;
        if (is_ib) begin bus.i_ibuf_ddr3_fault = eng_fault; bus.i_ibuf_bsy = 0; end
        else       begin bus.i_obuf_ddr3_fault = eng_fault; bus.i_obuf_bsy = 0; end
        @(posedge ui_clk); #1;
        bus.i_ibuf_ddr3_fault = 0; bus.i_obuf_ddr3_fault = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    item_t cur;
    int    c;
    int    ack_at;
    int    ib_n;
    int    ob_n;
    cur = '{default: 0};
    ack_at = 0; ib_n = 0; ob_n = 0;
    forever begin
      @(negedge ui_clk);
      if (!rst_n) begin
        mon_active = 0;
      end else begin
        if (bus.o_ibuf_go && bus.o_obuf_go)
          chk("both_go_high", 1, 0);
        if (bus.o_c0_ack || bus.o_c1_ack) begin
          ack_count++;
          c = bus.o_c1_ack ? 1 : 0;
          chk("single_ack", {bus.o_c1_ack, bus.o_c0_ack} == 2'b11, 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_ack_client", c, -1);
          end else begin
            cur = exp_q.pop_front();
            $display("ack  cyc=%0d client=%0d wr=%0d cnt=%0d", cyc, c, bus.o_ibuf_go, bus.o_ibuf_count);
            chk("ack_client", c, cur.client);
            if (cur.ack_cyc >= 0) chk("ack_cycle", cyc, cur.ack_cyc);
            chk("ibuf_count", bus.o_ibuf_count, cur.cnt);
            chk("obuf_count", bus.o_obuf_count, cur.cnt);
            chk("ibuf_start_addrb", bus.o_ibuf_start_addrb, cur.ba);
            chk("obuf_start_addra", bus.o_obuf_start_addra, cur.ba);
            chk("ibuf_ddr3_addrb", bus.o_ibuf_ddr3_addrb, cur.da);
            chk("obuf_ddr3_addra", bus.o_obuf_ddr3_addra, cur.da);
            chk("owner_at_ack", bus.o_owner, cur.client);
            chk("busy_at_ack", bus.o_busy, 1);
            chk("fault_cleared_at_ack", c ? bus.o_c1_fault : bus.o_c0_fault, 0);
            exp_fault[c] = 0;
            ack_at = cyc; ib_n = 0; ob_n = 0;
            mon_active = 1;
          end
        end
        if (mon_active) begin
          if (bus.o_ibuf_go) ib_n++;
          if (bus.o_obuf_go) ob_n++;
        end
        if (bus.o_c0_done || bus.o_c1_done) begin
          done_count++;
          c = bus.o_c1_done ? 1 : 0;
          $display("done cyc=%0d client=%0d fault=%0d go_cycles=%0d", cyc, c,
                   c ? bus.o_c1_fault : bus.o_c0_fault, ib_n + ob_n);
          if (!mon_active) begin
            chk("unexpected_done_client", c, -1);
          end else begin
            chk("done_client", c, cur.client);
            chk("done_delay", cyc - ack_at, cur.done_dly);
            chk("done_fault", c ? bus.o_c1_fault : bus.o_c0_fault, cur.fault);
            exp_fault[c] = cur.fault;
            chk("other_fault", c ? bus.o_c0_fault : bus.o_c1_fault, exp_fault[1-c]);
            chk("sel_go_cycles", cur.wr ? ib_n : ob_n, cur.go_cycles);
            chk("other_go_cycles", cur.wr ? ob_n : ib_n, 0);
            mon_active = 0;
          end
        end
      end
    end
  end

  task automatic push(input int c, input logic wr, input int cnt, input int ba,
                      input int da, input logic f, input int go, input int dly,
                      input int ackc);
    item_t it;
    it = '{client: c, wr: wr, cnt: cnt, ba: ba, da: da, fault: f,
           go_cycles: go, done_dly: dly, ack_cyc: ackc};
    exp_q.push_back(it);
  endtask

  task automatic set_req(input int c, input logic wr, input int cnt,
                         input int ba, input int da);
    if (c == 0) begin
      bus.i_c0_wr = wr; bus.i_c0_count = cnt[9:0];
      bus.i_c0_buf_addr = ba[9:0]; bus.i_c0_ddr3_addr = da[27:0];
      bus.i_c0_req = 1;
    end else begin
      bus.i_c1_wr = wr; bus.i_c1_count = cnt[9:0];
      bus.i_c1_buf_addr = ba[9:0]; bus.i_c1_ddr3_addr = da[27:0];
      bus.i_c1_req = 1;
    end
  endtask

  task automatic wait_ack(input int c);
    for (int i = 0; i < 300; i++) begin
      @(negedge ui_clk);
      if ((c == 0 && bus.o_c0_ack) || (c == 1 && bus.o_c1_ack)) begin
        if (c == 0) bus.i_c0_req = 0; else bus.i_c1_req = 0;
        return;
      end
    end
    fail_now(c == 0 ? "wait_ack_c0" : "wait_ack_c1");
    if (c == 0) bus.i_c0_req = 0; else bus.i_c1_req = 0;
  endtask

  task automatic issue(input int c, input logic wr, input int cnt,
                       input int ba, input int da);
    set_req(c, wr, cnt, ba, da);
    wait_ack(c);
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 400; i++) begin
      @(negedge ui_clk);
      if (exp_q.size() == 0 && !mon_active && !bus.o_busy) return;
    end
    fail_now("wait_quiet");
  endtask

  task automatic contention_round(input int ba0, input int da0, input int ba1, input int da1);
    @(posedge ui_clk); #1;
    push(0, 0, 8, ba0, da0, 0, 2, 7, cyc + 1);   // c0 read wins the tie
    push(1, 1, 3, ba1, da1, 0, 2, 7, -1);        // c1 write follows
    fork
      issue(0, 0, 8, ba0, da0);
      issue(1, 1, 3, ba1, da1);
    join
    wait_quiet();
  endtask

  initial begin
    int saved;
    exp_fault[0] = 0; exp_fault[1] = 0;
    bus.i_app_phy_init_done = 1;
    bus.i_c0_req = 0; bus.i_c0_wr = 0; bus.i_c0_count = 0;
    bus.i_c0_buf_addr = 0; bus.i_c0_ddr3_addr = 0;
    bus.i_c1_req = 0; bus.i_c1_wr = 0; bus.i_c1_count = 0;
    bus.i_c1_buf_addr = 0; bus.i_c1_ddr3_addr = 0;

    // Reset state.
    repeat (3) @(posedge ui_clk);
    #1;
    chk("reset_all_outputs", any_out, 0);
    rst_n = 1;
    @(posedge ui_clk); #1;
    chk("post_reset_busy", bus.o_busy, 0);
    chk("post_reset_outputs", any_out, 0);

    // Simultaneous requests, two rounds: grants 0,1,0,1.
    eng_dur = 5; eng_respond = 1; eng_fault = 0;
    contention_round(10'h010, 28'h2000, 10'h020, 28'h3000);
    contention_round(10'h030, 28'h4000, 10'h040, 28'h5000);

    // c0 write, count 4, 10-cycle engine job.
    eng_dur = 10;
    @(posedge ui_clk); #1;
    push(0, 1, 4, 10'h005, 28'h100, 0, 2, 12, cyc + 1);
    issue(0, 1, 4, 10'h005, 28'h100);
    wait_quiet();

    // c1 read, engine never answers: timeout fault.
    eng_respond = 0;
    @(posedge ui_clk); #1;
    push(1, 0, 7, 10'h3ff, 28'hfffffff, 1, 16, 16, cyc + 1);
    issue(1, 0, 7, 10'h3ff, 28'hfffffff);
    wait_quiet();
    eng_respond = 1;

    // c0 read, engine reports obuf fault; c1 fault stays set.
    eng_dur = 3; eng_fault = 1;
    @(posedge ui_clk); #1;
    push(0, 0, 9, 10'h100, 28'h0abcdef, 1, 2, 5, cyc + 1);
    issue(0, 0, 9, 10'h100, 28'h0abcdef);
    wait_quiet();
    eng_fault = 0;

    // c1 zero-count job: ack clears c1 fault, done one cycle later, no go.
    @(posedge ui_clk); #1;
    push(1, 1, 0, 10'h055, 28'h555, 0, 0, 1, cyc + 1);
    issue(1, 1, 0, 10'h055, 28'h555);
    wait_quiet();

    // Init low blocks the grant; raising it grants on the next edge.
    eng_dur = 4;
    bus.i_app_phy_init_done = 0;
    saved = ack_count;
    @(posedge ui_clk); #1;
    set_req(0, 1, 2, 10'h0aa, 28'h1234);
    repeat (6) @(posedge ui_clk);
    #1;
    chk("no_ack_while_init_low", ack_count, saved);
    push(0, 1, 2, 10'h0aa, 28'h1234, 0, 2, 6, cyc + 1);
    bus.i_app_phy_init_done = 1;
    wait_ack(0);
    wait_quiet();

    // Async reset in the middle of RUN: outputs clear at once, no done.
    eng_dur = 10;
    @(posedge ui_clk); #1;
    push(1, 1, 5, 10'h123, 28'h777, 0, 2, 12, cyc + 1);
    issue(1, 1, 5, 10'h123, 28'h777);
    repeat (4) @(posedge ui_clk);
    #3;
    saved = done_count;
    rst_n = 0;
    #1;
    chk("async_reset_outputs", any_out, 0);
    repeat (15) @(posedge ui_clk);
    #1;
    chk("no_done_after_reset", done_count, saved);
    chk("outputs_held_in_reset", any_out, 0);
    rst_n = 1;
    exp_fault[0] = 0; exp_fault[1] = 0;
    repeat (3) @(posedge ui_clk);
    #1;
    chk("idle_after_reset_release", bus.o_busy, 0);
    chk("no_done_after_release", done_count, saved);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr3_xfer_sched.md
# ddr3_xfer_sched

Two-client scheduler in front of the DDR3 transfer engine. It accepts buffer-to-DDR3 (write) and DDR3-to-buffer (read) transfer jobs from two requesters and arbitrates between them round-robin. It drives the engine's ibuf/obuf go, count and address inputs, tracks the engine busy/fault handshake, and returns per-client completion and fault status. It sits in the `ui_clk` domain between the Wishbone-facing control logic and the DDR3 transfer engine.

## Interface
- `BUF_DEPTH`, 10, width of buffer addresses and transfer counts.
- `MEM_ADDR_DEPTH`, 28, width of the DDR3 address.
- `START_TIMEOUT`, 16, cycles to wait for engine busy to rise after go.

- `ui_clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_app_phy_init_done`  in  1  no grant issued while low.
- `i_cN_req`  in  1  (N=0,1) job request; held until `o_cN_ack`.
- `i_cN_wr`  in  1  1 = buffer→DDR3, 0 = DDR3→buffer.
- `i_cN_count`  in  BUF_DEPTH  transfer count.
- `i_cN_buf_addr`  in  BUF_DEPTH  buffer start address.
- `i_cN_ddr3_addr`  in  MEM_ADDR_DEPTH  DDR3 start address.
- `o_cN_ack`  out  1  one-cycle pulse; job parameters latched.
- `o_cN_done`  out  1  one-cycle pulse; job finished.
- `o_cN_fault`  out  1  level; result of last job; cleared on next `o_cN_ack`.
- `o_ibuf_go`, `o_obuf_go`  out  1  engine start strobes.
- `o_ibuf_count`, `o_obuf_count`  out  BUF_DEPTH  latched count.
- `o_ibuf_start_addrb`, `o_obuf_start_addra`  out  BUF_DEPTH  latched buffer address.
- `o_ibuf_ddr3_addrb`, `o_obuf_ddr3_addra`  out  MEM_ADDR_DEPTH  latched DDR3 address.
- `i_ibuf_bsy`, `i_obuf_bsy`  in  1  engine busy.
- `i_ibuf_ddr3_fault`, `i_obuf_ddr3_fault`  in  1  engine fault.
- `o_busy`  out  1  job in flight, i.e. state ≠ IDLE.
- `o_owner`  out  1  client owning the current or last job.

## Operation
- States:
  - IDLE: if `i_app_phy_init_done` and any req, grant; else hold.
  - ISSUE: assert the go line for the selected direction.
  - RUN: wait for busy to fall.
  - COMPLETE: report to the owner.
- Arbitration:
  - With exactly one req, grant that client.
  - With both, grant the client ≠ `last_owner`.
  - `last_owner` resets to 1, so client 0 wins the first tie.
- Grant (IDLE → ISSUE):
  - Latch wr, count, buf_addr and ddr3_addr into both ibuf and obuf output registers.
  - Pulse `o_cN_ack`, clear `o_cN_fault`, set `o_owner`.
- Zero count: grant, ack, then go straight to COMPLETE. No go is issued, and done pulses without fault.
- ISSUE:
  - `o_ibuf_go` (wr=1) or `o_obuf_go` (wr=0) is high; the other stays low.
  - When the selected busy is seen high: drop go and enter RUN.
  - If busy stays low for `START_TIMEOUT` cycles: drop go, set the owner's fault, enter COMPLETE.
- RUN:
  - Non-selected busy and fault inputs are ignored.
  - On selected busy low: capture the selected engine fault into `o_cN_fault`, enter COMPLETE.
- COMPLETE: pulse `o_cN_done`, set `last_owner` to the owner, return to IDLE.
- `i_app_phy_init_done` falling mid-job does not abort the job; it only blocks new grants.
- A req still high after done is treated as a new job and goes through arbitration again.

## Timing
- Reset: every output is 0. State is IDLE, the timeout counter is 0, and `last_owner` is 1.
- Req seen in IDLE at edge T:
  - ack and go are high in cycle T+1.
  - Engine busy rises at T+2.
  - go falls in cycle T+3.
- Busy observed low at edge B: done and fault are valid in cycle B+1, and the next grant is possible at edge B+2.
- Minimum spacing between go pulses is 4 cycles, so go is never high while the engine is still leaving its transfer state.
- Timeout counter:
  - Width is ≥ clog2(`START_TIMEOUT`+1).
  - Cleared on grant; increments each ISSUE cycle with busy low.
  - Fires when it reaches `START_TIMEOUT`.
- Async reset mid-job: outputs clear immediately, no done is emitted, and the pending ack is lost.

## Test plan
- Client 0 write, count=4, ddr3_addr=0x100, model busy for 10 cycles → ack at T+1, `o_ibuf_go` high for 2 cycles, `o_ibuf_count`=4, one c0 done, fault=0.
- Both clients request at once after reset (c0 read, c1 write) → c0 first using obuf lines, then c1 using ibuf lines; repeating gives alternating grants 0,1,0,1.
- Client 1 read where the engine never asserts busy → go held 16 cycles, `o_c1_fault`=1 with a done pulse; fault clears on the next c1 ack.
- Engine returns `i_obuf_ddr3_fault`=1 when busy falls → `o_c0_fault`=1, the other client's fault unaffected.
- count=0 request → ack, done 1 cycle later, no go pulse, fault=0.
- `i_app_phy_init_done`=0 with req high → no ack; init rises → ack next cycle. `rst_n` asserted mid-RUN → all outputs 0 immediately, no done.
